// File: rtl/pipelined_skip_adder.sv
// rtl/pipelined_skip_adder.sv - carry-skip adder split into STAGES pipelined slices with valid/ready flow control
// Each stage finishes one slice; higher slices of A/B ride along until their stage comes up.

module pipelined_skip_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / BLOCK;

    if ((WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_cfg
        $error("pipelined_skip_adder: WIDTH must be a multiple of STAGES*BLOCK");
    end

    // Returns {carry_out, sum} for one slice; each group either ripples or forwards its carry-in.
    function automatic logic [SW:0] skip_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                             input logic cin);
        logic [SW-1:0] s;
        logic          c;
        logic          gc;
        logic          rc;
        logic          p;
        s = '0;
        c = cin;
        for (int g = 0; g < NG; g++) begin
            gc = c;
            rc = c;
            p  = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                s[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i] ^ rc;
                rc = (x[g*BLOCK+i] & y[g*BLOCK+i]) | (rc & (x[g*BLOCK+i] ^ y[g*BLOCK+i]));
                p  = p & (x[g*BLOCK+i] ^ y[g*BLOCK+i]);
            end
            c = p ? gc : rc;
        end
        return {c, s};
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_v_in;

    // A stage may advance if it or any stage downstream of it has room.
    always_comb begin
        logic l_full;
        l_full = 1'b1;
        w_adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            l_full   = l_full & r_v[k];
            w_adv[k] = out_ready | ~l_full;
        end
    end

    assign w_v_in    = (r_v << 1) | STAGES'(in_valid);
    assign in_ready  = ~rst & w_adv[0];
    assign out_valid = r_v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_v_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int YW = WIDTH - k * SW;

        logic [WIDTH-1:0] w_x;
        logic [YW-1:0]    w_y;
        logic             w_c;
        logic [SW:0]      w_res;
        logic [WIDTH-1:0] w_x_nxt;
        logic             w_ld;
        logic [WIDTH-1:0] r_x;
        logic             r_c;

        if (k == 0) begin : g_src
            assign w_x = a;
            assign w_y = sub ? ~b : b;
            assign w_c = sub | carry_in;
        end else begin : g_src
            assign w_x = g_stage[k-1].r_x;
            assign w_y = g_stage[k-1].g_fwd.r_y;
            assign w_c = g_stage[k-1].r_c;
        end

        assign w_res = skip_add(w_x[k*SW +: SW], w_y[SW-1:0], w_c);
        assign w_ld  = w_adv[k] & w_v_in[k];

        always_comb begin
            w_x_nxt              = w_x;
            w_x_nxt[k*SW +: SW]  = w_res[SW-1:0];
        end

        // Data registers only move with a valid beat so empty stages never disturb the outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_x <= '0;
                r_c <= 1'b0;
            end else if (w_ld) begin
                r_x <= w_x_nxt;
                r_c <= w_res[SW];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [YW-SW-1:0] r_y;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_y <= '0;
                end else if (w_ld) begin
                    r_y <= w_y[YW-1:SW];
                end
            end
        end else begin : g_last
            logic r_ov;
            // Carry into the MSB is recovered as x ^ y ^ sum at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ov <= 1'b0;
                end else if (w_ld) begin
                    r_ov <= w_x[WIDTH-1] ^ w_y[SW-1] ^ w_res[SW-1] ^ w_res[SW];
                end
            end
            assign sum       = r_x;
            assign carry_out = r_c;
            assign overflow  = r_ov;
        end
    end

endmodule

// File: tb/tb_pipelined_skip_adder.sv
// tb/tb_pipelined_skip_adder.sv - self-checking bench for pipelined_skip_adder (32/4/2 and 64/8/4)

module tb_pipelined_skip_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst_32, in_valid_32, in_ready_32, cin_32, sub_32;
    logic        out_valid_32, out_ready_32, cout_32, ov_32;
    logic [31:0] a_32, b_32, sum_32;

    logic        rst_64, in_valid_64, in_ready_64, cin_64, sub_64;
    logic        out_valid_64, out_ready_64, cout_64, ov_64;
    logic [63:0] a_64, b_64, sum_64;

    pipelined_skip_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut32 (
        .clk(clk), .rst(rst_32), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .a(a_32), .b(b_32), .carry_in(cin_32), .sub(sub_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32),
        .sum(sum_32), .carry_out(cout_32), .overflow(ov_32)
    );

    pipelined_skip_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst_64), .in_valid(in_valid_64), .in_ready(in_ready_64),
        .a(a_64), .b(b_64), .carry_in(cin_64), .sub(sub_64),
        .out_valid(out_valid_64), .out_ready(out_ready_64),
        .sum(sum_64), .carry_out(cout_64), .overflow(ov_64)
    );

    typedef struct {
        logic [65:0] r;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   cyc32 = 0, cyc64 = 0, nout32 = 0, nout64 = 0;
    bit   lat32 = 1'b1, lat64 = 1'b1;

    // Reference: plain integer arithmetic; result packed as {overflow, carry_out, sum[63:0]}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] x0, input logic [63:0] y0,
                                            input logic ci, input logic sb);
        logic [63:0] m, x, y, s;
        logic [64:0] t;
        logic        co, ov;
        m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x  = x0 & m;
        y  = (sb ? ~y0 : y0) & m;
        t  = {1'b0, x} + {1'b0, y} + {64'd0, (sb | ci)};
        s  = t[63:0] & m;
        co = t[w];
        ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step32(input logic r, input logic v, input logic [31:0] aa, input logic [31:0] bb,
                          input logic ci, input logic sb, input logic ordy);
        exp_t e;
        @(negedge clk);
        rst_32 = r; in_valid_32 = v; a_32 = aa; b_32 = bb;
        cin_32 = ci; sub_32 = sb; out_ready_32 = ordy;
        #1;
        cyc32++;
        if (r) begin
            q32.delete();
            chk("rst_in_ready_32", in_ready_32, 0);
        end else begin
            if (out_valid_32 && out_ready_32) begin
                nout32++;
                if (q32.size() == 0) begin
                    chk("spurious_out_32", out_valid_32, 0);
                end else begin
                    e = q32.pop_front();
                    chk("sum_32", sum_32, e.r[31:0]);
                    chk("carry_out_32", cout_32, e.r[64]);
                    chk("overflow_32", ov_32, e.r[65]);
                    if (lat32) chk("latency_32", cyc32 - e.cyc, 2);
                end
            end
            if (v && in_ready_32) begin
                e.r   = ref_add(32, {32'd0, aa}, {32'd0, bb}, ci, sb);
                e.cyc = cyc32;
                q32.push_back(e);
            end
        end
    endtask

    task automatic step64(input logic r, input logic v, input logic [63:0] aa, input logic [63:0] bb,
                          input logic ci, input logic sb, input logic ordy);
        exp_t e;
        @(negedge clk);
        rst_64 = r; in_valid_64 = v; a_64 = aa; b_64 = bb;
        cin_64 = ci; sub_64 = sb; out_ready_64 = ordy;
        #1;
        cyc64++;
        if (r) begin
            q64.delete();
            chk("rst_in_ready_64", in_ready_64, 0);
        end else begin
            if (out_valid_64 && out_ready_64) begin
                nout64++;
                if (q64.size() == 0) begin
                    chk("spurious_out_64", out_valid_64, 0);
                end else begin
                    e = q64.pop_front();
                    chk("sum_64", sum_64, e.r[63:0]);
                    chk("carry_out_64", cout_64, e.r[64]);
                    chk("overflow_64", ov_64, e.r[65]);
                    if (lat64) chk("latency_64", cyc64 - e.cyc, 4);
                end
            end
            if (v && in_ready_64) begin
                e.r   = ref_add(64, aa, bb, ci, sb);
                e.cyc = cyc64;
                q64.push_back(e);
            end
        end
    endtask

    task automatic idle32(input logic ordy);
        step32(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy);
    endtask

    task automatic idle64(input logic ordy);
        step64(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, ordy);
    endtask

    logic [31:0] ra [3];
    logic [31:0] rb [3];
    logic        rc [3];
    logic        rs [3];
    logic [65:0] frozen;
    logic        taken, have, bv, br, bc, bs;
    logic [63:0] ba, bb;
    int          n0, acc, budget;

    initial begin
        rst_32 = 1'b1; in_valid_32 = 1'b0; a_32 = '0; b_32 = '0; cin_32 = 1'b0; sub_32 = 1'b0; out_ready_32 = 1'b1;
        rst_64 = 1'b1; in_valid_64 = 1'b0; a_64 = '0; b_64 = '0; cin_64 = 1'b0; sub_64 = 1'b0; out_ready_64 = 1'b1;

        // Reset with in_valid held high: nothing may be accepted.
        step32(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
        step32(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
        idle32(1'b1);
        chk("post_rst_out_valid", out_valid_32, 0);
        chk("post_rst_sum", sum_32, 0);
        chk("post_rst_carry", cout_32, 0);
        chk("post_rst_ovf", ov_32, 0);
        chk("post_rst_in_ready", in_ready_32, 1);

        // Full skip path.
        step32(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        idle32(1'b1);
        chk("skip_lat1_out_valid", out_valid_32, 0);
        idle32(1'b1);
        chk("skip_out_valid", out_valid_32, 1);
        chk("skip_sum", sum_32, 32'h0000_0000);
        chk("skip_carry", cout_32, 1);
        chk("skip_ovf", ov_32, 0);

        // Signed overflow and subtract.
        step32(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step32(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        idle32(1'b1);
        chk("ovf_sum", sum_32, 32'h8000_0000);
        chk("ovf_carry", cout_32, 0);
        chk("ovf_ovf", ov_32, 1);
        idle32(1'b1);
        chk("sub_sum", sum_32, 32'hFFFF_FFFE);
        chk("sub_carry", cout_32, 0);
        chk("sub_ovf", ov_32, 0);
        idle32(1'b1);

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++) begin
            step32(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
            chk("b2b_in_ready", in_ready_32, 1);
        end
        idle32(1'b1); idle32(1'b1); idle32(1'b1);
        chk("b2b_drained", q32.size(), 0);

        // Stall with three beats offered.
        lat32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        frozen = ref_add(32, {32'd0, ra[0]}, {32'd0, rb[0]}, rc[0], rs[0]);
        n0 = nout32;
        step32(1'b0, 1'b1, ra[0], rb[0], rc[0], rs[0], 1'b0);
        step32(1'b0, 1'b1, ra[1], rb[1], rc[1], rs[1], 1'b0);
        chk("stall_accept2", in_ready_32, 1);
        for (int i = 0; i < 3; i++) begin
            step32(1'b0, 1'b1, ra[2], rb[2], rc[2], rs[2], 1'b0);
            chk("stall_in_ready", in_ready_32, 0);
            chk("stall_out_valid", out_valid_32, 1);
            chk("stall_frozen", {ov_32, cout_32, 32'd0, sum_32}, frozen);
        end
        taken = 1'b0;
        for (int i = 0; i < 5 && !taken; i++) begin
            step32(1'b0, 1'b1, ra[2], rb[2], rc[2], rs[2], 1'b1);
            taken = in_ready_32;
        end
        chk("stall_b3_taken", taken, 1);
        for (int i = 0; i < 4; i++) idle32(1'b1);
        chk("stall_emitted", nout32 - n0, 3);
        chk("stall_drained", q32.size(), 0);

        // Reset with two beats in flight.
        n0 = nout32;
        step32(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
        step32(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
        step32(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle32(1'b1);
        chk("flush_out_valid", out_valid_32, 0);
        chk("flush_in_ready", in_ready_32, 1);
        lat32 = 1'b1;
        step32(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1);
        idle32(1'b1);
        chk("flush_new_lat1", out_valid_32, 0);
        idle32(1'b1);
        chk("flush_new_out_valid", out_valid_32, 1);
        idle32(1'b1); idle32(1'b1);
        chk("flush_emitted", nout32 - n0, 1);

        // Wide configuration: reset, unstalled latency, then randomized handshakes.
        step64(1'b1, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
        step64(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        idle64(1'b1);
        chk("w_rst_out_valid", out_valid_64, 0);
        chk("w_rst_sum", sum_64, 0);
        chk("w_rst_in_ready", in_ready_64, 1);
        step64(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle64(1'b1);
            chk("w_lat_early", out_valid_64, 0);
        end
        idle64(1'b1);
        chk("w_lat_out_valid", out_valid_64, 1);
        lat64 = 1'b0;

        acc = 0; budget = 0; have = 1'b0;
        ba = '0; bb = '0; bc = 1'b0; bs = 1'b0;
        while (acc < 10000 && budget < 60000) begin
            if (!have) begin
                ba = {$urandom, $urandom};
                bb = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) bb = ~ba;
                bc = 1'($urandom);
                bs = 1'($urandom);
                have = 1'b1;
            end
            bv = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 3) != 0);
            step64(1'b0, bv, ba, bb, bc, bs, br);
            if (bv && in_ready_64) begin
                acc++;
                have = 1'b0;
            end
            budget++;
        end
        for (int i = 0; i < 50 && q64.size() > 0; i++) idle64(1'b1);
        chk("w_accepted", acc, 10000);
        chk("w_drained", q64.size(), 0);
        chk("w_emitted", nout64, 10001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
